sobel_row_window: RTL and testbench
===================================

// Module: sobel_row_window
// PURPOSE
//  Upstream feeder for the Sobel accelerator core. Accepts image rows streamed from the read-memory interface.
//  Keeps a sliding 3-row vertical window and presents it as srow2sacc_row1/2/3_data, where row1 is the oldest (top) row.
//  Emits one window per accepted row once three rows of the current column strip are held, under a valid/ready handshake.
// PARAMETERS
//  NUM_ACC   4                  output pixels per window; equals `NUM_SOBEL_ACCELERATORS
//  IDATA_W   (NUM_ACC+2)*8      row word width; equals `SOBEL_IDATA_WIDTH (derived, do not override)
// PORTS
//  clk                     in   1        system clock
//  reset                   in   1        synchronous, active-high reset
//  smem2srow_data          in   IDATA_W  incoming row word, byte 0 = rightmost pixel
//  smem2srow_valid         in   1        row word valid
//  smem2srow_first         in   1        word is first row of a column strip (qualified by valid)
//  smem2srow_last          in   1        word is last row of a column strip (qualified by valid)
//  srow2smem_ready         out  1        block can accept a row this cycle
//  srow2sacc_row1_data     out  IDATA_W  top (oldest) row of window
//  srow2sacc_row2_data     out  IDATA_W  middle row
//  srow2sacc_row3_data     out  IDATA_W  bottom (newest) row
//  srow2sacc_valid         out  1        window valid
//  srow2sacc_last          out  1        window is last of its strip
//  sacc2srow_ready         in   1        downstream consumed window
//  srow_short_col          out  1        1-cycle pulse: strip ended with fewer than 3 rows
// BEHAVIOUR
//  - Reset: all row registers 0, state EMPTY, srow2sacc_valid=0, srow2sacc_last=0, srow_short_col=0, stats 0.
//  - accept = smem2srow_valid & srow2smem_ready.
//  - srow2smem_ready = ~srow2sacc_valid | sacc2srow_ready. Combinational from registers and sacc2srow_ready; no input-to-output path from smem2srow_*.
//  - On accept: row1<=row2, row2<=row3, row3<=smem2srow_data. With first=1, row1/row2 are loaded 0 and row3<=data.
//  - FSM states EMPTY, ONE, TWO, FULL. Transitions happen on accept only:
//      - first=1 -> ONE, regardless of the current state.
//      - otherwise EMPTY->ONE, ONE->TWO, TWO->FULL, FULL->FULL.
//  - Window output: srow2sacc_valid is set the cycle after an accept whose next state is FULL.
//    srow2sacc_last <= smem2srow_last on that same accept.
//  - Latency: the window is valid 1 cycle after the 3rd row of a strip is accepted.
//  - Hold: while valid & ~sacc2srow_ready, the rows, valid and last stay stable and ready=0.
//  - Simultaneous consume and accept: the window is replaced in the same edge, so throughput is 1 row/cycle.
//  - Valid clears on sacc2srow_ready when no accept produces a new window.
//  - last=1 on an accept that reaches FULL: next state EMPTY after the window is emitted. The window carries last=1.
//  - last=1 on an accept whose next state is ONE or TWO: no window, state EMPTY, srow_short_col pulses 1 cycle.
//    This includes first=last=1.
//  - first=1 while in TWO or FULL, or with an unconsumed window pending: a pending window is still held until consumed, because ready gates the accept.
//    Stale rows are discarded and no short pulse is raised.
//  - Reset asserted mid-strip or mid-stall returns everything to reset values on the next edge. The pending window is dropped.
//  - Data width: pure register movement, no arithmetic on pixels.
// CONFIGURATION
//  - SOBEL_ROW_STATS_EN defined adds output ports:
//      - srow_win_count    out 32: windows handed off (valid & ready).
//      - srow_stall_count  out 32: cycles with valid & ~ready.
//    Both saturate at 32'hFFFF_FFFF and clear on reset.
//  - SOBEL_ROW_STATS_EN undefined: ports and counters are absent, with identical functional behaviour.
// STRUCTURE
//  - sobel_pkg: NUM_ACC default, IDATA_W derivation, and the FSM state encoding (2-bit: EMPTY=0, ONE=1, TWO=2, FULL=3).
//  - One sub-module, sobel_sat_counter (32-bit saturating incrementer), instantiated twice under SOBEL_ROW_STATS_EN.
//  - FSM, row shift registers and output register live in this module.
// TESTING
//  1. Reset, then rows A=0x01..,B=0x02..,C=0x03.. (first on A), ready=1: one window row1=A,row2=B,row3=C, valid 1 cycle after C.
//  2. Strip of 5 rows R0..R4 with last on R4 and continuous ready: 3 windows back-to-back, the 3rd with last=1; state EMPTY afterwards.
//  3. sacc2srow_ready=0 for 4 cycles with a window pending: srow2smem_ready=0 and outputs stable. Stats build: stall_count=4.
//  4. Strip of 2 rows (last on 2nd): no valid, srow_short_col=1 for exactly 1 cycle. Then first=last=1 on one row: another pulse.
//  5. first=1 mid-strip after 2 rows of an old strip, then 2 more rows: the first window is {0x00 stale-free: new R0,R1,R2} only after the 3rd new row.
//  6. Assert reset for 1 cycle while a window is stalled: valid=0, rows=0, ready=1 next cycle. Stats build: counters=0.

Source files
------------

// File: rtl/sobel_pkg.sv
// ============================================================================
// Module   : sobel_pkg
// Desc     : Shared sizing constants and row-window FSM encoding for the
//            Sobel front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

  localparam int c_NUM_ACC_DEFAULT = 4;

  // Each window word carries one extra pixel on either side of the outputs.
  function automatic int sobel_idata_w(input int num_acc);
    return (num_acc + 2) * 8;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FULL  = 2'd3
  } srow_state_t;

endpackage

`default_nettype wire

// File: rtl/sobel_sat_counter.sv
// ============================================================================
// Module   : sobel_sat_counter
// Desc     : 32-bit event counter that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/sobel_row_window.sv
// ============================================================================
// Module   : sobel_row_window
// Desc     : Sliding 3-row vertical window feeding the Sobel accelerators.
//            Optional statistics counters enabled by SOBEL_ROW_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_row_window
  import sobel_pkg::*;
#(
  parameter  int NUM_ACC = c_NUM_ACC_DEFAULT,
  localparam int IDATA_W = sobel_idata_w(NUM_ACC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDATA_W-1:0] smem2srow_data,
  input  logic               smem2srow_valid,
  input  logic               smem2srow_first,
  input  logic               smem2srow_last,
  output logic               srow2smem_ready,
  output logic [IDATA_W-1:0] srow2sacc_row1_data,
  output logic [IDATA_W-1:0] srow2sacc_row2_data,
  output logic [IDATA_W-1:0] srow2sacc_row3_data,
  output logic               srow2sacc_valid,
  output logic               srow2sacc_last,
  input  logic               sacc2srow_ready,
  output logic               srow_short_col
`ifdef SOBEL_ROW_STATS_EN
  ,
  output logic [31:0]        srow_win_count,
  output logic [31:0]        srow_stall_count
`endif
);

  srow_state_t        r_state;
  srow_state_t        w_next_state;
  logic [IDATA_W-1:0] r_row1;
  logic [IDATA_W-1:0] r_row2;
  logic [IDATA_W-1:0] r_row3;
  logic               r_valid;
  logic               r_last;
  logic               r_short;
  logic               w_ready;
  logic               w_accept;

  // A pending window blocks new rows unless it is consumed this same cycle.
  assign w_ready  = ~r_valid | sacc2srow_ready;
  assign w_accept = smem2srow_valid & w_ready;

  always_comb begin
    w_next_state = r_state;
    if (smem2srow_first) begin
      w_next_state = ST_ONE;
    end else begin
      case (r_state)
        ST_EMPTY: w_next_state = ST_ONE;
        ST_ONE:   w_next_state = ST_TWO;
        ST_TWO:   w_next_state = ST_FULL;
        ST_FULL:  w_next_state = ST_FULL;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_row1  <= '0;
      r_row2  <= '0;
      r_row3  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_short <= 1'b0;
      if (w_accept) begin
        if (smem2srow_first) begin
          r_row1 <= '0;
          r_row2 <= '0;
        end else begin
          r_row1 <= r_row2;
          r_row2 <= r_row3;
        end
        r_row3 <= smem2srow_data;

        r_state <= smem2srow_last ? ST_EMPTY : w_next_state;

        if (w_next_state == ST_FULL) begin
          r_valid <= 1'b1;
          r_last  <= smem2srow_last;
        end else if (sacc2srow_ready) begin
          r_valid <= 1'b0;
        end

        // A strip that closes before three rows never yields a window.
        r_short <= smem2srow_last && (w_next_state != ST_FULL);
      end else if (sacc2srow_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign srow2smem_ready     = w_ready;
  assign srow2sacc_row1_data = r_row1;
  assign srow2sacc_row2_data = r_row2;
  assign srow2sacc_row3_data = r_row3;
  assign srow2sacc_valid     = r_valid;
  assign srow2sacc_last      = r_last;
  assign srow_short_col      = r_short;

`ifdef SOBEL_ROW_STATS_EN
  logic w_win_inc;
  logic w_stall_inc;

  assign w_win_inc   = r_valid & sacc2srow_ready;
  assign w_stall_inc = r_valid & ~sacc2srow_ready;

  sobel_sat_counter u_win_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_win_inc),
    .o_count (srow_win_count)
  );

  sobel_sat_counter u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (srow_stall_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sobel_row_window.sv
// ============================================================================
// Module   : tb_sobel_row_window
// Desc     : Directed self-checking bench for sobel_row_window (default and
//            SOBEL_ROW_STATS_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_row_window;

  localparam int W = 48;

  logic         clk;
  logic         reset;
  logic [W-1:0] smem2srow_data;
  logic         smem2srow_valid;
  logic         smem2srow_first;
  logic         smem2srow_last;
  logic         srow2smem_ready;
  logic [W-1:0] srow2sacc_row1_data;
  logic [W-1:0] srow2sacc_row2_data;
  logic [W-1:0] srow2sacc_row3_data;
  logic         srow2sacc_valid;
  logic         srow2sacc_last;
  logic         sacc2srow_ready;
  logic         srow_short_col;
`ifdef SOBEL_ROW_STATS_EN
  logic [31:0]  srow_win_count;
  logic [31:0]  srow_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  sobel_row_window dut (
    .clk                 (clk),
    .reset               (reset),
    .smem2srow_data      (smem2srow_data),
    .smem2srow_valid     (smem2srow_valid),
    .smem2srow_first     (smem2srow_first),
    .smem2srow_last      (smem2srow_last),
    .srow2smem_ready     (srow2smem_ready),
    .srow2sacc_row1_data (srow2sacc_row1_data),
    .srow2sacc_row2_data (srow2sacc_row2_data),
    .srow2sacc_row3_data (srow2sacc_row3_data),
    .srow2sacc_valid     (srow2sacc_valid),
    .srow2sacc_last      (srow2sacc_last),
    .sacc2srow_ready     (sacc2srow_ready),
    .srow_short_col      (srow_short_col)
`ifdef SOBEL_ROW_STATS_EN
    ,
    .srow_win_count      (srow_win_count),
    .srow_stall_count    (srow_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic drive(input logic [W-1:0] d, input logic f, input logic l, input logic v);
    smem2srow_data  = d;
    smem2srow_first = f;
    smem2srow_last  = l;
    smem2srow_valid = v;
    @(negedge clk);
  endtask

  task automatic idle();
    drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sacc2srow_ready = 1'b1;
    smem2srow_data = '0; smem2srow_valid = 1'b0;
    smem2srow_first = 1'b0; smem2srow_last = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (srow2sacc_valid !== 1'b0 || srow2sacc_last !== 1'b0 || srow_short_col !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b last=%b short=%b, want 0 0 0", srow2sacc_valid, srow2sacc_last, srow_short_col);
    end
    checks++;
    if (srow2sacc_row1_data !== '0 || srow2sacc_row2_data !== '0 || srow2sacc_row3_data !== '0) begin
      errors++; $display("FAIL reset_rows: %h %h %h, want all zero", srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    checks++;
    if (srow2smem_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", srow2smem_ready);
    end
`ifdef SOBEL_ROW_STATS_EN
    checks++;
    if (srow_win_count !== 32'd0 || srow_stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats: win=%0d stall=%0d want 0 0", srow_win_count, srow_stall_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic_window();
    drive(48'h010101010101, 1'b1, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_no_early_A: valid=%b want 0", srow2sacc_valid);
    end
    drive(48'h020202020202, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_no_early_B: valid=%b want 0", srow2sacc_valid);
    end
    drive(48'h030303030303, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b1 || srow2sacc_last !== 1'b0 ||
        srow2sacc_row1_data !== 48'h010101010101 || srow2sacc_row2_data !== 48'h020202020202 ||
        srow2sacc_row3_data !== 48'h030303030303) begin
      errors++; $display("FAIL basic_window: v=%b l=%b rows %h %h %h, want 1 0 010101010101 020202020202 030303030303",
                         srow2sacc_valid, srow2sacc_last, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    idle();
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_consumed: valid=%b want 0", srow2sacc_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rr [0:4];
    for (int i = 0; i < 5; i++) rr[i] = 48'h100000000000 + 48'(i) * 48'h010101010101;
    for (int i = 0; i < 5; i++) begin
      drive(rr[i], (i == 0), (i == 4), 1'b1);
      if (i >= 2) begin
        checks++;
        if (srow2sacc_valid !== 1'b1 || srow2sacc_last !== (i == 4) ||
            srow2sacc_row1_data !== rr[i-2] || srow2sacc_row2_data !== rr[i-1] || srow2sacc_row3_data !== rr[i]) begin
          errors++; $display("FAIL b2b_win%0d: v=%b l=%b rows %h %h %h, want 1 %b %h %h %h", i - 2,
                             srow2sacc_valid, srow2sacc_last, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data,
                             (i == 4), rr[i-2], rr[i-1], rr[i]);
        end
      end else begin
        checks++;
        if (srow2sacc_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_early%0d: valid=%b want 0", i, srow2sacc_valid);
        end
      end
    end
    // After last the state is EMPTY: rows without first need three more rows.
    drive(48'hAAAAAAAAAAAA, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty_after_last: valid=%b want 0", srow2sacc_valid);
    end
    drive(48'hBBBBBBBBBBBB, 1'b0, 1'b0, 1'b1);
    drive(48'hCCCCCCCCCCCC, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b1 || srow2sacc_row1_data !== 48'hAAAAAAAAAAAA ||
        srow2sacc_row2_data !== 48'hBBBBBBBBBBBB || srow2sacc_row3_data !== 48'hCCCCCCCCCCCC) begin
      errors++; $display("FAIL b2b_restart_win: v=%b rows %h %h %h, want 1 AAAAAAAAAAAA BBBBBBBBBBBB CCCCCCCCCCCC",
                         srow2sacc_valid, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    idle();
  endtask

  task automatic test_stall();
    sacc2srow_ready = 1'b0;
    drive(48'h010101010101, 1'b1, 1'b0, 1'b1);
    drive(48'h020202020202, 1'b0, 1'b0, 1'b1);
    drive(48'h030303030303, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(48'h040404040404, 1'b0, 1'b1, 1'b1);
      checks++;
      if (srow2smem_ready !== 1'b0 || srow2sacc_valid !== 1'b1 ||
          srow2sacc_row1_data !== 48'h010101010101 || srow2sacc_row2_data !== 48'h020202020202 ||
          srow2sacc_row3_data !== 48'h030303030303) begin
        errors++; $display("FAIL stall_hold%0d: rdy=%b v=%b rows %h %h %h, want 0 1 010101010101 020202020202 030303030303",
                           i, srow2smem_ready, srow2sacc_valid, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
      end
    end
`ifdef SOBEL_ROW_STATS_EN
    checks++;
    if (srow_stall_count !== 32'd4 || srow_win_count !== 32'd5) begin
      errors++; $display("FAIL stall_stats: stall=%0d win=%0d want 4 5", srow_stall_count, srow_win_count);
    end
`endif
    // Release: consume and accept the waiting row on the same edge.
    sacc2srow_ready = 1'b1;
    drive(48'h040404040404, 1'b0, 1'b1, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b1 || srow2sacc_last !== 1'b1 ||
        srow2sacc_row1_data !== 48'h020202020202 || srow2sacc_row2_data !== 48'h030303030303 ||
        srow2sacc_row3_data !== 48'h040404040404) begin
      errors++; $display("FAIL stall_release: v=%b l=%b rows %h %h %h, want 1 1 020202020202 030303030303 040404040404",
                         srow2sacc_valid, srow2sacc_last, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    idle();
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: valid=%b want 0", srow2sacc_valid);
    end
  endtask

  task automatic test_short_col();
    drive(48'h0E0E0E0E0E0E, 1'b1, 1'b0, 1'b1);
    drive(48'h0F0F0F0F0F0F, 1'b0, 1'b1, 1'b1);
    checks++;
    if (srow_short_col !== 1'b1 || srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL short_two_rows: short=%b valid=%b want 1 0", srow_short_col, srow2sacc_valid);
    end
    idle();
    checks++;
    if (srow_short_col !== 1'b0 || srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL short_one_cycle: short=%b valid=%b want 0 0", srow_short_col, srow2sacc_valid);
    end
    drive(48'h111111111111, 1'b1, 1'b1, 1'b1);
    checks++;
    if (srow_short_col !== 1'b1 || srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL short_first_last: short=%b valid=%b want 1 0", srow_short_col, srow2sacc_valid);
    end
    idle();
    checks++;
    if (srow_short_col !== 1'b0) begin
      errors++; $display("FAIL short_first_last_clear: short=%b want 0", srow_short_col);
    end
  endtask

  task automatic test_restart();
    drive(48'h505050505050, 1'b1, 1'b0, 1'b1);
    drive(48'h515151515151, 1'b0, 1'b0, 1'b1);
    drive(48'h606060606060, 1'b1, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b0 || srow_short_col !== 1'b0 || srow2sacc_row1_data !== '0 ||
        srow2sacc_row2_data !== '0 || srow2sacc_row3_data !== 48'h606060606060) begin
      errors++; $display("FAIL restart_discard: v=%b short=%b rows %h %h %h, want 0 0 0 0 606060606060",
                         srow2sacc_valid, srow_short_col, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    drive(48'h616161616161, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b0) begin
      errors++; $display("FAIL restart_no_early: valid=%b want 0", srow2sacc_valid);
    end
    drive(48'h626262626262, 1'b0, 1'b0, 1'b1);
    checks++;
    if (srow2sacc_valid !== 1'b1 || srow2sacc_row1_data !== 48'h606060606060 ||
        srow2sacc_row2_data !== 48'h616161616161 || srow2sacc_row3_data !== 48'h626262626262) begin
      errors++; $display("FAIL restart_window: v=%b rows %h %h %h, want 1 606060606060 616161616161 626262626262",
                         srow2sacc_valid, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    sacc2srow_ready = 1'b0;
    drive(48'h717171717171, 1'b1, 1'b0, 1'b1);
    drive(48'h727272727272, 1'b0, 1'b0, 1'b1);
    drive(48'h737373737373, 1'b0, 1'b0, 1'b1);
    idle();
    checks++;
    if (srow2sacc_valid !== 1'b1 || srow2smem_ready !== 1'b0) begin
      errors++; $display("FAIL rst_stall_setup: valid=%b ready=%b want 1 0", srow2sacc_valid, srow2smem_ready);
    end
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checks++;
    if (srow2sacc_valid !== 1'b0 || srow2smem_ready !== 1'b1 || srow2sacc_row1_data !== '0 ||
        srow2sacc_row2_data !== '0 || srow2sacc_row3_data !== '0) begin
      errors++; $display("FAIL rst_stall_clear: v=%b rdy=%b rows %h %h %h, want 0 1 0 0 0",
                         srow2sacc_valid, srow2smem_ready, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data);
    end
`ifdef SOBEL_ROW_STATS_EN
    checks++;
    if (srow_win_count !== 32'd0 || srow_stall_count !== 32'd0) begin
      errors++; $display("FAIL rst_stall_stats: win=%0d stall=%0d want 0 0", srow_win_count, srow_stall_count);
    end
`endif
    sacc2srow_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_back_to_back();
    test_stall();
    test_short_col();
    test_restart();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
